// File: rtl/neuron_pkg.sv
// Shared types for the neuron register file.
package neuron_pkg;

   typedef enum logic [0:0] {
      RF_IDLE  = 1'b0,
      RF_CLEAR = 1'b1
   } reg_file_state_t;

endpackage

// File: rtl/neuron_reg_file.sv
// Dual-read, single-write register file with a one-entry-per-cycle clear sweep.
// Optional macro NEURON_REG_FILE_BYPASS_EN forwards same-edge accepted writes to the read ports.
module neuron_reg_file
   import neuron_pkg::*;
#(
   parameter  int NUM_BIT  = 16,
   parameter  int NUM_REG  = 8,
   localparam int ADDR_BIT = $clog2(NUM_REG)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                reg_write,
   input  logic [ADDR_BIT-1:0] write_addr,
   input  logic [NUM_BIT-1:0]  write_data,
   input  logic [ADDR_BIT-1:0] read_addr_a,
   input  logic [ADDR_BIT-1:0] read_addr_b,
   input  logic                clear,
   output logic [NUM_BIT-1:0]  read_data_a,
   output logic [NUM_BIT-1:0]  read_data_b,
   output logic                busy
);

   localparam logic [ADDR_BIT-1:0] LAST_PTR = ADDR_BIT'(NUM_REG - 1);

   reg_file_state_t     state, state_nxt;
   logic [ADDR_BIT-1:0] clr_ptr, clr_ptr_nxt;
   logic [NUM_BIT-1:0]  mem [NUM_REG];
   logic [NUM_BIT-1:0]  rd_a_nxt, rd_b_nxt;
   logic                wr_accept;

   // clear beats a simultaneous write; nothing is accepted mid-sweep
   assign wr_accept = reg_write && (state == RF_IDLE) && !clear;
   assign busy      = (state == RF_CLEAR);

   always_comb begin
      state_nxt   = state;
      clr_ptr_nxt = clr_ptr;
      case (state)
         RF_IDLE: begin
            if (clear) begin
               state_nxt   = RF_CLEAR;
               clr_ptr_nxt = '0;
            end
         end
         RF_CLEAR: begin
            clr_ptr_nxt = clr_ptr + 1'b1;
            if (clr_ptr == LAST_PTR) begin
               state_nxt   = RF_IDLE;
               clr_ptr_nxt = '0;
            end
         end
         default: begin
            state_nxt   = RF_IDLE;
            clr_ptr_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= RF_IDLE;
         clr_ptr <= '0;
      end else begin
         state   <= state_nxt;
         clr_ptr <= clr_ptr_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REG; i++) mem[i] <= '0;
      end else if (state == RF_CLEAR) begin
         mem[clr_ptr] <= '0;
      end else if (wr_accept) begin
         mem[write_addr] <= write_data;
      end
   end

   always_comb begin
      rd_a_nxt = mem[read_addr_a];
      rd_b_nxt = mem[read_addr_b];
`ifdef NEURON_REG_FILE_BYPASS_EN
      if (wr_accept && (write_addr == read_addr_a)) rd_a_nxt = write_data;
      if (wr_accept && (write_addr == read_addr_b)) rd_b_nxt = write_data;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         read_data_a <= '0;
         read_data_b <= '0;
      end else begin
         read_data_a <= rd_a_nxt;
         read_data_b <= rd_b_nxt;
      end
   end

endmodule

// File: doc/neuron_reg_file.md
NEURON_REG_FILE -- requirements
Module: neuron_reg_file

Interface
REQ-001 Parameter NUM_BIT, default 16, SHALL set the data width of every entry.
REQ-002 Parameter NUM_REG, default 8, SHALL set the number of entries; it SHALL be a power of two and at least 2.
REQ-003 Localparam ADDR_BIT = $clog2(NUM_REG) SHALL set the width of every address port.
REQ-004 Ports SHALL be:
- clk  input  1  sole clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset
- reg_write  input  1  write enable
- write_addr  input  ADDR_BIT  write entry index
- write_data  input  NUM_BIT  write value
- read_addr_a  input  ADDR_BIT  port A read index
- read_addr_b  input  ADDR_BIT  port B read index
- clear  input  1  start a clear-all sweep
- read_data_a  output  NUM_BIT  port A read value (registered)
- read_data_b  output  NUM_BIT  port B read value (registered)
- busy  output  1  high while a clear sweep is running

Function
REQ-005 A write SHALL commit write_data to entry write_addr at the posedge where reg_write=1, busy=0 and clear=0.
REQ-006 Entries not written or cleared SHALL hold their value.
REQ-007 Read latency SHALL be one cycle: read_data_x after posedge n reflects the entry addressed by read_addr_x at edge n.
REQ-008 Both read ports SHALL be independent; equal addresses SHALL return equal data.
REQ-009 The read value for an address written at the same edge SHALL be as defined in REQ-019/REQ-020.
REQ-010 The FSM SHALL have states RF_IDLE and RF_CLEAR. RF_IDLE transitions to RF_CLEAR on clear=1. RF_CLEAR transitions to RF_IDLE after the edge that clears entry NUM_REG-1.
REQ-011 In RF_CLEAR, a clear pointer starting at 0 SHALL zero one entry per cycle in ascending order, so a sweep lasts exactly NUM_REG cycles.
REQ-012 busy SHALL be 1 exactly while the FSM is in RF_CLEAR, and SHALL deassert at the edge that clears entry NUM_REG-1.
REQ-013 Writes requested while busy=1 SHALL be dropped silently, with no queuing.
REQ-014 clear asserted while busy=1 SHALL be ignored; the sweep SHALL not restart.
REQ-015 When clear=1 and reg_write=1 arrive together in RF_IDLE, clear SHALL win and the write SHALL be dropped.
REQ-016 Reads SHALL continue during a sweep; an entry reads 0 from the cycle after its clear edge onward.

Reset
REQ-017 When reset=1 at a posedge, all entries, read_data_a and read_data_b SHALL become 0, busy SHALL become 0, the FSM SHALL enter RF_IDLE and the clear pointer SHALL become 0.
REQ-018 Reset SHALL take priority over clear and reg_write, and SHALL abort any sweep in progress.

Configuration
REQ-019 With macro NEURON_REG_FILE_BYPASS_EN defined, a read whose address matches an accepted write at the same edge SHALL return write_data.
REQ-020 Without NEURON_REG_FILE_BYPASS_EN, such a read SHALL return the entry's pre-write contents.
REQ-021 Dropped writes (REQ-013, REQ-015) SHALL never be bypassed.

Structure
REQ-022 The state typedef reg_file_state_t {RF_IDLE, RF_CLEAR} SHALL reside in shared package neuron_pkg.
REQ-023 No sub-module SHALL be used: storage SHALL be an inline array, and the FSM and pointer SHALL be local to neuron_reg_file.

Verification
REQ-024 Write 0x1234 to addr 3, then read A=3 and B=3 on the next cycle -> both ports return 0x1234 one cycle later.
REQ-025 Write 0x00AA to addr 5 while reading A=5 in the same cycle -> with bypass, A returns 0x00AA; without bypass, A returns the old value 0x0000.
REQ-026 Fill all 8 entries with 0xFFFF, pulse clear, and read A=7 every cycle -> busy is high for 8 cycles; A returns 0xFFFF until entry 7 is cleared, then 0x0000.
REQ-027 During a sweep, write 0x5555 to addr 0 and pulse clear again -> entry 0 stays 0 and busy still drops after exactly 8 cycles.
REQ-028 Apply clear and reg_write (addr 2, 0x0F0F) together -> entry 2 reads 0 after the sweep.
REQ-029 Assert reset at sweep cycle 3 -> busy reads 0 on the next cycle, all reads return 0, and a new clear starts a full 8-cycle sweep.
